// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC and IF/ID register, stall and redirect control.
// Optional FETCH_STATS_EN adds fetch_count/stall_count outputs.
module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [63:0] pc_current,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  logic [63:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  // redirect flushes IF/ID and beats stall
  always_comb begin
    pc_d         = redirect_en ? {redirect_pc[63:2], 2'b00} : stall ? pc_q : pc_q + 64'd4;
    ifid_pc_d    = redirect_en ? 64'd0 : stall ? ifid_pc_q : pc_q;
    ifid_instr_d = redirect_en ? NOP_INSTR : stall ? ifid_instr_q : imem_rdata;
    ifid_valid_d = redirect_en ? 1'b0 : stall ? ifid_valid_q : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 64'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end
  assign imem_addr  = pc_q;
  assign pc_current = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, stall_count_q;
  logic        load, held;
  assign load = !redirect_en && !stall;
  assign held = !redirect_en && stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_q + {31'd0, load};
      stall_count_q <= stall_count_q + {31'd0, held};
    end
  end
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule

// File: doc/if_stage.md
# if_stage

- Instruction-fetch stage with its IF/ID pipeline register. It sits directly upstream of the instruction-decode stage.
- It owns the 64-bit program counter and drives the instruction-memory address.
- It latches the fetched 32-bit instruction and its PC into the IF/ID register. That register feeds the decode stage's register-file and immediate-generator inputs.
- It applies stall and redirect (branch/jump flush) control from later stages.

## Interface
Clocking: one clock `clk`; reset `reset` is synchronous and active-high.

Parameters:
- `RESET_PC`, 64'h0: PC value loaded on reset.
- `NOP_INSTR`, 32'h00000013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold PC and IF/ID register.
- `redirect_en` in 1: load `redirect_pc` and flush IF/ID.
- `redirect_pc` in 64: redirect target; bits [1:0] are forced to 0.
- `imem_addr` out 64: equals current PC; combinational from the PC register.
- `imem_rdata` in 32: instruction at `imem_addr`, valid in the same cycle (combinational memory).
- `pc_current` out 64: current PC register value.
- `ifid_pc` out 64: PC of the instruction held in IF/ID.
- `ifid_instr` out 32: instruction held in IF/ID; goes to the decode stage's instruction input.
- `ifid_valid` out 1: IF/ID holds a real instruction, not a bubble.

## Operation
State:
- PC register (64b).
- IF/ID register {`ifid_pc`, `ifid_instr`, `ifid_valid`}.

Per-edge priority, highest first:
1. `reset`: PC←`RESET_PC`; `ifid_pc`←0, `ifid_instr`←`NOP_INSTR`, `ifid_valid`←0.
2. `redirect_en`: PC←{`redirect_pc`[63:2],2'b00}; IF/ID←bubble (`ifid_pc`←0, `NOP_INSTR`, valid 0). Redirect overrides `stall` in the same cycle.
3. `stall`: PC and IF/ID both hold.
4. Normal: IF/ID←{PC, `imem_rdata`, 1}; PC←PC+4.

Arithmetic:
- PC+4 is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
- PC[1:0] is always 0.

Bubbles and instruction content:
- No instruction decoding occurs here. The decode stage must treat `ifid_valid`=0 as a NOP.
- A bubble always carries `NOP_INSTR`, so decode writes only x0 even if it ignores valid.

## Timing
- Fetch-to-decode latency is 1 cycle: the instruction addressed in cycle N appears on `ifid_instr` after edge N+1.
- Steady-state throughput is one instruction per cycle.
- Redirect asserted in cycle N:
  - bubble visible after edge N+1;
  - first target instruction visible after edge N+2;
  - penalty: the one wrong-path fetch in flight is squashed.
- Stall is level-sensitive. Each stalled cycle holds outputs unchanged, and `imem_addr` stays constant.
- Reset mid-stream discards the IF/ID contents. The first fetch, from `RESET_PC`, appears one cycle after reset deasserts.
- Output values during reset (cycle after the reset edge):
  - `imem_addr` = `pc_current` = `RESET_PC`;
  - `ifid_pc` = 0;
  - `ifid_instr` = `NOP_INSTR`;
  - `ifid_valid` = 0.

## Configuration
Macro `FETCH_STATS_EN`.

When defined, the block adds two outputs:
- `fetch_count` out 32: counts edges that load a valid instruction into IF/ID (normal case only). Reset to 0; wraps modulo 2^32.
- `stall_count` out 32: counts edges where `stall`=1 and `redirect_en`=0 and `reset`=0. Reset to 0; wraps modulo 2^32.

When undefined, neither port nor counter exists, and all other behaviour is identical.

## Test plan
- **Reset then run:** `RESET_PC`=0, imem returns 32'hA000_0000|addr for 3 cycles → `ifid_pc` 0,4,8; `ifid_instr` A0000000, A0000004, A0000008; valid 1; `pc_current`=12.
- **Stall:** assert `stall` 2 cycles at PC=8 → `imem_addr` stays 8 and IF/ID holds {4, A0000004, 1}; after release, IF/ID={8, A0000008, 1}.
- **Redirect:** `redirect_en` with `redirect_pc`=0x103 at PC=16 →
  - next cycle `pc_current`=0x100 and IF/ID is a bubble (00000013, valid 0);
  - following cycle `ifid_pc`=0x100.
- **Redirect+stall same cycle:** redirect to 0x40 wins → PC=0x40, bubble.
- **Wrap and reset mid-run:**
  - PC=64'hFFFF_FFFF_FFFF_FFFC, normal fetch → PC becomes 0.
  - Reset asserted while `ifid_valid`=1 → valid 0, instr 00000013, PC=`RESET_PC`.
- **`FETCH_STATS_EN` build:** 5 normal + 2 stall + 1 redirect cycles → `fetch_count`=5, `stall_count`=2; reset → both 0.
